hex_display_bank: RTL

HEX_DISPLAY_BANK -- requirements
Module: hex_display_bank

---
 rtl/hex_display_bank.sv | 113 +++++++++++
 1 files changed

// File: rtl/hex_display_bank.sv
// Bank of NUM_DIGITS seven-segment drivers with shadow registers, per-digit blank/blink
// and optional leading-zero blanking. Segment outputs are active-low and registered.
module hex_display_bank #(
  parameter int NUM_DIGITS  = 4,
  parameter int BLINK_DIV   = 25_000_000,
  parameter bit LZ_SUPPRESS = 1'b0
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] HEX,
  output logic                    blink_phase
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
  localparam logic [6:0] SEG_OFF = 7'h7F;

  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [NUM_DIGITS-1:0]   blink_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    phase_q, phase_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

  function automatic logic [6:0] seg_encode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (Reset) begin
      digits_q <= '0;
      blank_q  <= '1;
      blink_q  <= '0;
    end else if (load) begin
      digits_q <= digits;
      blank_q  <= blank_mask;
      blink_q  <= blink_mask;
    end
  end

  // A load restarts the blink cycle and wins over a coincident wrap.
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (load) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // zero_run tracks "this digit and every higher one are zero", scanning from the top.
  always_comb begin
    logic       zero_run;
    logic       off;
    logic [3:0] v;
    hex_d    = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v        = digits_q[4*i +: 4];
      zero_run = zero_run & (v == 4'h0);
      off      = blank_q[i] | (blink_q[i] & ~phase_q) | (LZ_SUPPRESS & (i > 0) & zero_run);
      hex_d[7*i +: 7] = off ? SEG_OFF : seg_encode(v);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      hex_q <= '1;
    end else begin
      hex_q <= hex_d;
    end
  end

  assign HEX         = hex_q;
  assign blink_phase = phase_q;

endmodule
